sobel_window_ctrl: RTL and testbench

Sequences the three 8-bit line buffers that feed the 3x3 Sobel kernel. It tracks pixel column and line count from the incoming pixel stream and rotates the line buffers round-robin. It generates write enables and addresses, plus buffer-role selects telling the datapath which buffer holds the top, middle and bottom rows. It flags when a complete 3x3 window is available. It sits between the camera/pixel front end and the line-buffer/kernel datapath.

---
 rtl/sobel_window_ctrl.sv | 122 ++++++++++++
 tb/tb_sobel_window_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/sobel_window_ctrl.sv
// Line-buffer sequencer for the 3x3 Sobel kernel: column/line tracking,
// round-robin buffer roles and window-valid flag. Option: SOBEL_LINE_CHECK_EN.
module sobel_window_ctrl #(
  parameter int LINE_WIDTH = 32,
  parameter int ADDR_W     = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pix_valid,
  input  logic              h_sync,
  input  logic              v_sync,
  output logic [2:0]        wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [1:0]        top_sel,
  output logic [1:0]        mid_sel,
  output logic [1:0]        bot_sel,
  output logic              win_valid,
  output logic [ADDR_W-1:0] win_col,
  output logic [15:0]       win_row,
  output logic              busy,
  output logic              line_err
);

  typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

  localparam logic [ADDR_W:0] LW  = (ADDR_W+1)'(LINE_WIDTH);
  localparam logic [ADDR_W:0] TWO = (ADDR_W+1)'(2);

  state_t          state;
  logic [ADDR_W:0] col;
  logic [15:0]     line_cnt;
  logic [1:0]      wr_buf;
  logic [1:0]      nxt_buf;
  logic            active;
  logic            in_line;
  logic            do_write;

  // Decode whether this cycle's pixel lands in a line buffer
  always_comb begin
    active   = (state != IDLE);
    in_line  = (col < LW);
    do_write = !rst && active && pix_valid && !v_sync && in_line;
    nxt_buf  = (wr_buf == 2'd2) ? 2'd0 : wr_buf + 2'd1;
    wr_en    = do_write ? (3'b001 << wr_buf) : 3'b000;
    wr_addr  = col[ADDR_W-1:0];
    rd_addr  = col[ADDR_W-1:0];
    busy     = active;
  end

  // Frame FSM, column/line counters, buffer rotation and window flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      col       <= '0;
      line_cnt  <= '0;
      wr_buf    <= 2'd0;
      bot_sel   <= 2'd0;
      mid_sel   <= 2'd2;
      top_sel   <= 2'd1;
      win_valid <= 1'b0;
      win_col   <= '0;
      win_row   <= '0;
    end else begin
      win_valid <= 1'b0;
      if (do_write && state == RUN && col >= TWO) begin
        win_valid <= 1'b1;
        win_col   <= col[ADDR_W-1:0] - ADDR_W'(1);
        win_row   <= line_cnt - 16'd1;
      end
      if (v_sync) begin
        state    <= FILL;
        col      <= '0;
        line_cnt <= '0;
        wr_buf   <= 2'd0;
        bot_sel  <= 2'd0;
        mid_sel  <= 2'd2;
        top_sel  <= 2'd1;
      end else if (active) begin
        if (pix_valid && in_line)
          col <= col + 1'b1;
        if (h_sync) begin
          col     <= '0;
          wr_buf  <= nxt_buf;
          bot_sel <= nxt_buf;
          mid_sel <= wr_buf;
          top_sel <= (nxt_buf == 2'd2) ? 2'd0 : nxt_buf + 2'd1;
          if (line_cnt != 16'hFFFF)
            line_cnt <= line_cnt + 16'd1;
          if (state == FILL && line_cnt == 16'd1)
            state <= RUN;
        end
      end
    end
  end

`ifdef SOBEL_LINE_CHECK_EN
  logic [ADDR_W:0] eff_col;
  logic            short_line;
  logic            long_line;

  // Line length seen at h_sync counts a pixel arriving in the same cycle
  always_comb begin
    eff_col    = col + {{ADDR_W{1'b0}}, do_write};
    short_line = active && !v_sync && h_sync && (eff_col != LW);
    long_line  = active && !v_sync && pix_valid && !in_line;
  end

  // Sticky line-length error, cleared at frame start
  always_ff @(posedge clk) begin
    if (rst)
      line_err <= 1'b0;
    else if (v_sync)
      line_err <= 1'b0;
    else if (short_line || long_line)
      line_err <= 1'b1;
  end
`else
  assign line_err = 1'b0;
`endif

endmodule

// File: tb/tb_sobel_window_ctrl.sv
// Directed bench for sobel_window_ctrl with a frame-level reference model.
module tb_sobel_window_ctrl;

  localparam int LW = 32;
  localparam int AW = 6;
`ifdef SOBEL_LINE_CHECK_EN
  localparam bit LE = 1'b1;
`else
  localparam bit LE = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          pix_valid = 1'b0;
  logic          h_sync = 1'b0;
  logic          v_sync = 1'b0;
  logic [2:0]    wr_en;
  logic [AW-1:0] wr_addr, rd_addr, win_col;
  logic [1:0]    top_sel, mid_sel, bot_sel;
  logic          win_valid, busy, line_err;
  logic [15:0]   win_row;

  sobel_window_ctrl #(.LINE_WIDTH(LW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .pix_valid(pix_valid), .h_sync(h_sync),
    .v_sync(v_sync), .wr_en(wr_en), .wr_addr(wr_addr), .rd_addr(rd_addr),
    .top_sel(top_sel), .mid_sel(mid_sel), .bot_sel(bot_sel),
    .win_valid(win_valid), .win_col(win_col), .win_row(win_row),
    .busy(busy), .line_err(line_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: frame active flag, pixels in current line,
  // lines completed this frame, pending window output.
  bit m_active;
  int m_col;
  int m_lines;
  bit m_err;
  bit m_wv;
  int m_wcol, m_wrow;
  int pulses, last_wcol, last_wrow;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp,
               $time);
    end
  endtask

  function automatic bit exp_write(input bit pv, input bit vs, input bit r);
    return !r && m_active && pv && !vs && (m_col < LW);
  endfunction

  task automatic compare(input bit pv, input bit vs, input bit r);
    bit w;
    w = exp_write(pv, vs, r);
    chk("wr_en", {29'd0, wr_en}, w ? (32'd1 << (m_lines % 3)) : 32'd0);
    chk("wr_addr", {26'd0, wr_addr}, m_col);
    chk("rd_addr", {26'd0, rd_addr}, m_col);
    chk("bot_sel", {30'd0, bot_sel}, m_lines % 3);
    chk("mid_sel", {30'd0, mid_sel}, (m_lines + 2) % 3);
    chk("top_sel", {30'd0, top_sel}, (m_lines + 1) % 3);
    chk("win_valid", {31'd0, win_valid}, m_wv);
    if (m_wv) begin
      chk("win_col", {26'd0, win_col}, m_wcol);
      chk("win_row", {16'd0, win_row}, m_wrow);
      pulses++;
      last_wcol = m_wcol;
      last_wrow = m_wrow;
    end
    chk("busy", {31'd0, busy}, m_active);
    chk("line_err", {31'd0, line_err}, m_err);
  endtask

  task automatic model_step(input bit pv, input bit hs, input bit vs,
                            input bit r);
    bit w;
    w = exp_write(pv, vs, r);
    if (r) begin
      m_active = 0; m_col = 0; m_lines = 0; m_err = 0; m_wv = 0;
    end else begin
      m_wv = w && (m_lines >= 2) && (m_col >= 2);
      if (m_wv) begin
        m_wcol = m_col - 1;
        m_wrow = m_lines - 1;
      end
      if (vs) begin
        m_active = 1; m_col = 0; m_lines = 0; m_err = 0;
      end else if (m_active) begin
        if (pv) begin
          if (m_col < LW) m_col++;
          else if (LE) m_err = 1;
        end
        if (hs) begin
          if (LE && m_col != LW) m_err = 1;
          m_col = 0;
          m_lines++;
        end
      end
    end
  endtask

  task automatic cyc(input bit pv, input bit hs, input bit vs, input bit r);
    pix_valid = pv; h_sync = hs; v_sync = vs; rst = r;
    #1;
    compare(pv, vs, r);
    @(posedge clk);
    model_step(pv, hs, vs, r);
    @(negedge clk);
  endtask

  task automatic pix_line(input int n);
    repeat (n) cyc(1, 0, 0, 0);
    cyc(0, 1, 0, 0);
  endtask

  initial begin
    @(posedge clk);
    @(posedge clk);
    model_step(0, 0, 0, 1);
    @(negedge clk);
    cyc(0, 0, 0, 1);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_top", {30'd0, top_sel}, 1);
    chk("rst_mid", {30'd0, mid_sel}, 2);

    // Traffic before any v_sync is ignored
    repeat (3) cyc(1, 0, 0, 0);
    cyc(0, 1, 0, 0);
    cyc(1, 1, 0, 0);
    cyc(0, 0, 0, 0);
    chk("idle_busy", {31'd0, busy}, 0);
    chk("idle_bot", {30'd0, bot_sel}, 0);

    // Three full lines
    cyc(0, 0, 1, 0);
    chk("fill_busy", {31'd0, busy}, 1);
    pix_line(32);
    pix_line(32);
    chk("l2_top", {30'd0, top_sel}, 0);
    chk("l2_mid", {30'd0, mid_sel}, 1);
    chk("l2_bot", {30'd0, bot_sel}, 2);
    pulses = 0;
    pix_line(32);
    chk("l2_pulses", pulses, 30);
    chk("l2_lastcol", last_wcol, 30);
    chk("l2_row", last_wrow, 1);

    // Wrap of the write buffer
    chk("l3_top", {30'd0, top_sel}, 1);
    chk("l3_mid", {30'd0, mid_sel}, 2);
    chk("l3_bot", {30'd0, bot_sel}, 0);
    pix_line(32);
    chk("l3_row", last_wrow, 2);

    // h_sync with the last pixel, then v_sync with h_sync
    repeat (31) cyc(1, 0, 0, 0);
    cyc(1, 1, 0, 0);
    chk("hs_pix_bot", {30'd0, bot_sel}, 2);
    repeat (4) cyc(1, 0, 0, 0);
    cyc(1, 1, 1, 0);
    chk("vs_hs_bot", {30'd0, bot_sel}, 0);
    chk("vs_hs_addr", {26'd0, wr_addr}, 0);
    cyc(1, 0, 0, 0);

    // Short and long lines
    cyc(0, 0, 1, 0);
    pix_line(20);
    chk("short_err", {31'd0, line_err}, LE);
    cyc(0, 0, 0, 0);
    pix_line(34);
    chk("long_err", {31'd0, line_err}, LE);
    cyc(0, 0, 1, 0);
    chk("vs_clr_err", {31'd0, line_err}, 0);
    pix_line(33);
    chk("ovf_err", {31'd0, line_err}, LE);

    // Reset mid-line in RUN
    cyc(0, 0, 1, 0);
    pix_line(32);
    pix_line(32);
    repeat (15) cyc(1, 0, 0, 0);
    chk("mid_addr", {26'd0, wr_addr}, 15);
    cyc(1, 0, 0, 1);
    chk("mr_busy", {31'd0, busy}, 0);
    chk("mr_top", {30'd0, top_sel}, 1);
    chk("mr_wv", {31'd0, win_valid}, 0);
    cyc(1, 0, 0, 0);
    cyc(0, 0, 1, 0);
    pix_line(32);
    pix_line(32);
    pulses = 0;
    pix_line(32);
    chk("rs_pulses", pulses, 30);
    cyc(0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
